frame_strobe_sequencer: RTL and testbench

//  Column-bottom config stage feeding the S_term_RAM_IO FrameStrobe chain.

---
 rtl/frame_strobe_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_frame_strobe_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_strobe_sequencer.sv
// ---------------------------------------------------------------------------
// frame_strobe_sequencer
//
// Column-bottom configuration stage that drives the FrameStrobe chain of one
// tile column. Frame-address words arrive from the bitstream controller over
// a valid/ready handshake. Each word carries {column, frame index}. Only words
// whose column field equals ColSelect produce a strobe. A strobe is a one-hot
// pulse on FrameStrobe, held for StrobeCycles clocks and then followed by
// GapCycles all-zero clocks before the next word is accepted.
//
// Ports
//   UserCLK          in   1     sole clock, rising edge
//   resetn           in   1     synchronous, active-low reset
//   FrameAddr        in   C+F   {column select, frame index}
//   FrameAddr_valid  in   1     a word is present on FrameAddr
//   FrameAddr_ready  out  1     a word can be accepted this cycle (combinational)
//   FrameStrobe      out  M     one-hot strobe towards the tile column
//   busy             out  1     high while a strobe or its guard gap is in progress
//   err_range        out  1     sticky: a matching word had index >= MaxFramesPerCol
//   strobe_count     out  16    completed strobes, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module frame_strobe_sequencer #(
   parameter int MaxFramesPerCol  = 20,
   parameter int FrameSelectWidth = 5,
   parameter int ColSelectWidth   = 5,
   parameter int ColSelect        = 0,
   parameter int StrobeCycles     = 2,
   parameter int GapCycles        = 1
) (
   input  logic                                       UserCLK,
   input  logic                                       resetn,
   input  logic [ColSelectWidth+FrameSelectWidth-1:0] FrameAddr,
   input  logic                                       FrameAddr_valid,
   output logic                                       FrameAddr_ready,
   output logic [MaxFramesPerCol-1:0]                 FrameStrobe,
   output logic                                       busy,
   output logic                                       err_range,
   output logic [15:0]                                strobe_count
);

   // Counter reload values. The counter counts down to zero, so the reload
   // is one less than the number of cycles spent in the state.
   localparam logic [3:0] STROBE_LOAD = 4'(StrobeCycles - 1);
   localparam bit         GAP_ENABLED = (GapCycles != 0);
   localparam logic [3:0] GAP_LOAD    = GAP_ENABLED ? 4'(GapCycles - 1) : 4'd0;

   localparam logic [ColSelectWidth-1:0]  COL_ID      = ColSelectWidth'(ColSelect);
   localparam logic [31:0]                MAX_FRAMES  = 32'(MaxFramesPerCol);
   localparam logic [MaxFramesPerCol-1:0] STROBE_ZERO = {MaxFramesPerCol{1'b0}};
   localparam logic [15:0]                COUNT_MAX   = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_GAP    = 2'd2
   } state_t;

   state_t                        state_r;
   state_t                        state_next_s;
   logic [3:0]                    cnt_r;
   logic [3:0]                    cnt_next_s;
   logic [MaxFramesPerCol-1:0]    strobe_r;
   logic [MaxFramesPerCol-1:0]    strobe_next_s;
   logic                          busy_r;
   logic                          busy_next_s;
   logic                          err_range_r;
   logic                          err_range_next_s;
   logic [15:0]                   count_r;
   logic [15:0]                   count_next_s;

   logic [ColSelectWidth-1:0]     col_s;
   logic [FrameSelectWidth-1:0]   idx_s;
   logic                          ready_s;
   logic                          transfer_s;
   logic                          col_match_s;
   logic                          idx_in_range_s;
   logic                          start_s;
   logic                          range_err_s;
   logic                          strobe_done_s;

   // Builds the one-hot strobe for a frame index. The index is compared at
   // its full width, so an index beyond the strobe width yields all zeros
   // instead of aliasing onto a low bit.
   function automatic logic [MaxFramesPerCol-1:0] frame_onehot(
      input logic [FrameSelectWidth-1:0] idx
   );
      logic [MaxFramesPerCol-1:0] oh;
      oh = STROBE_ZERO;
      for (int i = 0; i < MaxFramesPerCol; i++) begin
         if (32'(idx) == 32'(i)) begin
            oh[i] = 1'b1;
         end else begin
            oh[i] = 1'b0;
         end
      end
      return oh;
   endfunction

   // Split the incoming word into its column and frame-index fields.
   always_comb begin
      col_s = FrameAddr[ColSelectWidth+FrameSelectWidth-1:FrameSelectWidth];
      idx_s = FrameAddr[FrameSelectWidth-1:0];
   end

   // Handshake and word classification. Ready is forced low while reset is
   // asserted so the source never sees a word consumed during reset.
   always_comb begin
      ready_s        = (state_r == ST_IDLE) && resetn;
      transfer_s     = FrameAddr_valid && ready_s;
      col_match_s    = (col_s == COL_ID);
      // Range check on the zero-extended full field, never a truncated one.
      idx_in_range_s = (32'(idx_s) < MAX_FRAMES);
      start_s        = transfer_s && col_match_s && idx_in_range_s;
      range_err_s    = transfer_s && col_match_s && !idx_in_range_s;
      strobe_done_s  = (state_r == ST_STROBE) && (cnt_r == 4'd0);
   end

   // State and counter register.
   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_next_s = ST_STROBE;
               cnt_next_s   = STROBE_LOAD;
            end else begin
               // Non-matching and out-of-range words are consumed in place.
               state_next_s = ST_IDLE;
               cnt_next_s   = cnt_r;
            end
         end
         ST_STROBE: begin
            if (cnt_r == 4'd0) begin
               if (GAP_ENABLED) begin
                  state_next_s = ST_GAP;
                  cnt_next_s   = GAP_LOAD;
               end else begin
                  state_next_s = ST_IDLE;
                  cnt_next_s   = 4'd0;
               end
            end else begin
               state_next_s = ST_STROBE;
               cnt_next_s   = cnt_r - 4'd1;
            end
         end
         ST_GAP: begin
            if (cnt_r == 4'd0) begin
               state_next_s = ST_IDLE;
               cnt_next_s   = 4'd0;
            end else begin
               state_next_s = ST_GAP;
               cnt_next_s   = cnt_r - 4'd1;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            cnt_next_s   = 4'd0;
         end
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      strobe_next_s    = strobe_r;
      count_next_s     = count_r;
      err_range_next_s = err_range_r || range_err_s;
      busy_next_s      = (state_next_s != ST_IDLE);
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               // Strobe appears the cycle after the transfer.
               strobe_next_s = frame_onehot(idx_s);
            end else begin
               strobe_next_s = STROBE_ZERO;
            end
         end
         ST_STROBE: begin
            if (strobe_done_s) begin
               // A strobe only counts once it has run to completion.
               strobe_next_s = STROBE_ZERO;
               if (count_r != COUNT_MAX) begin
                  count_next_s = count_r + 16'd1;
               end else begin
                  count_next_s = count_r;
               end
            end else begin
               strobe_next_s = strobe_r;
            end
         end
         ST_GAP: begin
            strobe_next_s = STROBE_ZERO;
         end
         default: begin
            strobe_next_s = STROBE_ZERO;
         end
      endcase
   end

   // Output registers; reset drops any strobe in flight at the same edge.
   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         strobe_r    <= STROBE_ZERO;
         busy_r      <= 1'b0;
         err_range_r <= 1'b0;
         count_r     <= 16'd0;
      end else begin
         strobe_r    <= strobe_next_s;
         busy_r      <= busy_next_s;
         err_range_r <= err_range_next_s;
         count_r     <= count_next_s;
      end
   end

   assign FrameAddr_ready = ready_s;
   assign FrameStrobe     = strobe_r;
   assign busy            = busy_r;
   assign err_range       = err_range_r;
   assign strobe_count    = count_r;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for frame_strobe_sequencer (default parameters).
// Expected strobes are queued when a matching word is driven and popped by a
// monitor when a strobe appears on FrameStrobe. Inputs change and outputs are
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_frame_strobe_sequencer;

   localparam int STROBE_CYCLES = 2;

   logic        UserCLK;
   logic        resetn;
   logic [9:0]  FrameAddr;
   logic        FrameAddr_valid;
   logic        FrameAddr_ready;
   logic [19:0] FrameStrobe;
   logic        busy;
   logic        err_range;
   logic [15:0] strobe_count;

   int          checks;
   int          errors;
   logic [19:0] sb_q[$];
   logic [15:0] exp_count;
   logic        exp_err;
   bit          abort_expected;

   logic [19:0] mon_prev;
   int          mon_hi_len;
   logic [19:0] mon_exp;

   frame_strobe_sequencer dut (
      .UserCLK         (UserCLK),
      .resetn          (resetn),
      .FrameAddr       (FrameAddr),
      .FrameAddr_valid (FrameAddr_valid),
      .FrameAddr_ready (FrameAddr_ready),
      .FrameStrobe     (FrameStrobe),
      .busy            (busy),
      .err_range       (err_range),
      .strobe_count    (strobe_count)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      UserCLK = 1'b0;
      forever #5 UserCLK = ~UserCLK;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   // Drive one word and update the reference model.
   task automatic send(input int col, input int idx);
      logic [19:0] e;
      FrameAddr       = {5'(col), 5'(idx)};
      FrameAddr_valid = 1'b1;
      if (col == 0 && idx < 20) begin
         e = 20'd0;
         e[idx] = 1'b1;
         sb_q.push_back(e);
         exp_count = exp_count + 16'd1;
      end else if (col == 0) begin
         exp_err = 1'b1;
      end else begin
         exp_err = exp_err;
      end
   endtask

   // Strobe monitor: one-hot, scoreboard match on appearance, stability and width.
   initial begin
      mon_prev   = 20'd0;
      mon_hi_len = 0;
      forever begin
         @(negedge UserCLK);
         check("onehot", 32'($onehot0(FrameStrobe)), 32'd1);
         if (FrameStrobe !== 20'd0 && mon_prev === 20'd0) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected", 32'(FrameStrobe), 32'd0);
            end else begin
               mon_exp = sb_q.pop_front();
               check("sb_strobe", 32'(FrameStrobe), 32'(mon_exp));
            end
            mon_hi_len = 1;
         end else if (FrameStrobe !== 20'd0) begin
            check("strobe_stable", 32'(FrameStrobe), 32'(mon_prev));
            mon_hi_len++;
         end else if (mon_prev !== 20'd0 && !abort_expected) begin
            check("strobe_width", 32'(mon_hi_len), 32'(STROBE_CYCLES));
         end
         mon_prev = FrameStrobe;
      end
   end

   initial begin
      checks         = 0;
      errors         = 0;
      exp_count      = 16'd0;
      exp_err        = 1'b0;
      abort_expected = 1'b0;

      // 1: reset held two cycles with a word offered
      resetn          = 1'b0;
      FrameAddr       = {5'd3, 5'd7};
      FrameAddr_valid = 1'b1;
      @(negedge UserCLK);
      check("rst_strobe", 32'(FrameStrobe), 32'd0);
      check("rst_ready",  32'(FrameAddr_ready), 32'd0);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_count",  32'(strobe_count), 32'd0);
      check("rst_err",    32'(err_range), 32'd0);
      @(negedge UserCLK);
      check("rst2_ready", 32'(FrameAddr_ready), 32'd0);
      resetn          = 1'b1;
      FrameAddr_valid = 1'b0;
      @(negedge UserCLK);
      check("rel_ready", 32'(FrameAddr_ready), 32'd1);
      check("rel_busy",  32'(busy), 32'd0);

      // 2: single strobe {col 0, idx 7}
      send(0, 7);
      @(negedge UserCLK);
      FrameAddr_valid = 1'b0;
      check("s_c1_strobe", 32'(FrameStrobe), 32'h00080);
      check("s_c1_busy",   32'(busy), 32'd1);
      check("s_c1_ready",  32'(FrameAddr_ready), 32'd0);
      @(negedge UserCLK);
      check("s_c2_strobe", 32'(FrameStrobe), 32'h00080);
      @(negedge UserCLK);
      check("s_c3_strobe", 32'(FrameStrobe), 32'd0);
      check("s_c3_busy",   32'(busy), 32'd1);
      check("s_c3_ready",  32'(FrameAddr_ready), 32'd0);
      check("s_c3_count",  32'(strobe_count), 32'(exp_count));
      @(negedge UserCLK);
      check("s_c4_ready",  32'(FrameAddr_ready), 32'd1);
      check("s_c4_busy",   32'(busy), 32'd0);

      // 3: column filter {col 3, idx 7}
      send(3, 7);
      @(negedge UserCLK);
      FrameAddr_valid = 1'b0;
      check("col_strobe", 32'(FrameStrobe), 32'd0);
      check("col_busy",   32'(busy), 32'd0);
      check("col_ready",  32'(FrameAddr_ready), 32'd1);
      check("col_count",  32'(strobe_count), 32'(exp_count));
      check("col_err",    32'(err_range), 32'(exp_err));

      // 4: range errors, then the top legal index
      send(0, 20);
      @(negedge UserCLK);
      FrameAddr_valid = 1'b0;
      check("rng_err",    32'(err_range), 32'(exp_err));
      check("rng_strobe", 32'(FrameStrobe), 32'd0);
      check("rng_ready",  32'(FrameAddr_ready), 32'd1);
      check("rng_count",  32'(strobe_count), 32'(exp_count));
      send(0, 31);
      @(negedge UserCLK);
      FrameAddr_valid = 1'b0;
      check("rng31_strobe", 32'(FrameStrobe), 32'd0);
      check("rng31_busy",   32'(busy), 32'd0);
      send(0, 19);
      @(negedge UserCLK);
      FrameAddr_valid = 1'b0;
      check("top_strobe", 32'(FrameStrobe), 32'h80000);
      check("top_err",    32'(err_range), 32'(exp_err));
      repeat (3) @(negedge UserCLK);
      check("top_ready", 32'(FrameAddr_ready), 32'd1);
      check("top_count", 32'(strobe_count), 32'(exp_count));
      check("top_err2",  32'(err_range), 32'(exp_err));

      // 5: back-to-back with valid held high
      for (int k = 0; k < 3; k++) begin
         send(0, k);
         for (int c = 1; c <= 3; c++) begin
            @(negedge UserCLK);
            check("b2b_busy",  32'(busy), 32'd1);
            check("b2b_ready", 32'(FrameAddr_ready), 32'd0);
         end
         @(negedge UserCLK);
         check("b2b_ready_back", 32'(FrameAddr_ready), 32'd1);
      end
      FrameAddr_valid = 1'b0;
      check("b2b_count", 32'(strobe_count), 32'(exp_count));

      // 6: reset during the first strobe cycle
      abort_expected = 1'b1;
      send(0, 5);
      @(negedge UserCLK);
      FrameAddr_valid = 1'b0;
      check("mid_strobe", 32'(FrameStrobe), 32'h00020);
      resetn = 1'b0;
      @(negedge UserCLK);
      exp_count = 16'd0;
      exp_err   = 1'b0;
      check("mid_rst_strobe", 32'(FrameStrobe), 32'd0);
      check("mid_rst_busy",   32'(busy), 32'd0);
      check("mid_rst_count",  32'(strobe_count), 32'(exp_count));
      check("mid_rst_err",    32'(err_range), 32'(exp_err));
      check("mid_rst_ready",  32'(FrameAddr_ready), 32'd0);
      resetn = 1'b1;
      @(negedge UserCLK);
      abort_expected = 1'b0;
      check("mid_rel_ready", 32'(FrameAddr_ready), 32'd1);

      // Recovery strobe after the interrupted one
      send(0, 1);
      @(negedge UserCLK);
      FrameAddr_valid = 1'b0;
      repeat (3) @(negedge UserCLK);
      check("rec_count", 32'(strobe_count), 32'(exp_count));
      check("rec_ready", 32'(FrameAddr_ready), 32'd1);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
